multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Moore-style main control FSM for the multi-cycle CPU; the initiator side of the ALU control interface.
- Takes the opcode/funct fields of the latched instruction register and sequences fetch/decode/execute/memory/writeback over several cycles.
- Drives datapath enables, mux selects and the 4-bit ALU operation code, including shamt/shift selection, that the ALU responds to.
- Stalls on a memory-ready handshake.

Parameters:
- ALU_AND, 4'b0000, ALU op codes; all ALU_* codes live in the shared package.
- ALU_OR, 4'b0001; ALU_ADD, 4'b0010; ALU_SUB, 4'b0110; ALU_SLT, 4'b0111.
- ALU_NOR, 4'b1100; ALU_SLL, 4'b0011; ALU_LUI, 4'b0100; ALU_SLLV, 4'b0101.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- op_i  in  6  instr[31:26] from the instruction register.
- funct_i  in  6  instr[5:0].
- mem_ready_i  in  1  memory completed the current access this cycle.
- pc_write_o  out  1  unconditional PC load.
- pc_write_cond_o  out  1  PC load qualified by the branch condition.
- branch_ne_o  out  1  1 = branch if !zero, 0 = branch if zero.
- i_or_d_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- ir_write_o  out  1  instruction register load.
- reg_dst_o  out  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg_o  out  1  writeback data: 0 = ALUOut, 1 = MDR.
- reg_write_o  out  1  register file write.
- alu_src_a_o  out  1  ALU operand A: 0 = PC, 1 = rs.
- alu_src_b_o  out  2  ALU operand B: 0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- pc_source_o  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- alu_ctrl_o  out  4  ALU operation code.
- illegal_o  out  1  one-cycle pulse on an unsupported op/funct.
- instr_done_o  out  1  one-cycle pulse in an instruction's final state.

Behaviour:
- Reset: on a rising edge with rst_i=0, state <= FETCH. While rst_i=0, all outputs are forced to 0: no enables, selects 0, alu_ctrl_o = ALU_AND.
- Outputs are combinational from state plus op_i/funct_i (Moore with execute-state decode). The state register is the only flop.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_ctrl=ADD, pc_source=0.
  - ir_write and pc_write are asserted only when mem_ready_i=1. Then go to DECODE; otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, alu_ctrl=ADD (computes branch target). Next state by op_i:
  - 0x00 -> R_EXEC.
  - 0x23 (lw), 0x2B (sw) -> MEM_ADDR.
  - 0x04 (beq), 0x05 (bne) -> BRANCH.
  - 0x08 (addi), 0x0A (slti), 0x0D (ori), 0x0F (lui) -> I_EXEC.
  - 0x02 (j) -> JUMP.
  - any other op: illegal_o=1, go to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0. funct maps to alu_ctrl as follows, then go to R_WB:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT, 0x00 SLL, 0x04 SLLV.
  - any other funct: illegal_o=1, go to FETCH, no writeback.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1, go to FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=2. Mapping: addi ADD, slti SLT, ori OR, lui LUI. Go to I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1, go to FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_ctrl=ADD. Go to MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready_i=1, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1, go to FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready_i; in the ready cycle instr_done=1, then go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_ctrl=SUB, pc_write_cond=1, pc_source=1, branch_ne=(op==0x05), instr_done=1, go to FETCH.
- JUMP: pc_write=1, pc_source=2, instr_done=1, go to FETCH.
- Latency per instruction (zero wait states):
  - j: 3 cycles.
  - beq/bne: 3 cycles.
  - R-type and I-type: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
  - each mem_ready_i=0 cycle adds 1 cycle.
- mem_read/mem_write stay asserted and stable throughout a wait; the request is not dropped.
- Reset low mid-wait aborts the access: next state is FETCH and no write is issued.
- Unreachable state encodings go to FETCH on the next edge.

Decomposition:
- Shared package cpu_pkg: ALU_* codes, OP_* and FUNCT_* constants, state enum (4-bit encoding).
- One sub-module is natural: alu_op_decode, a combinational mapping of state class, op and funct to alu_ctrl_o plus an illegal flag. It can be reused by the single-cycle design.

Test Plan:
- Reset: hold rst_i=0 for 3 clocks -> all outputs 0. First cycle after release: mem_read_o=1, alu_ctrl_o=0010, alu_src_b_o=1.
- add (op 0x00, funct 0x20), mem_ready_i tied 1 -> alu_ctrl_o=0010 in cycle 3, reg_write_o=1 with reg_dst_o=1 in cycle 4, instr_done_o in cycle 4.
- lw (op 0x23), mem_ready_i low for 2 cycles in MEM_READ -> mem_read_o/i_or_d_o held for 3 cycles, mem_to_reg_o=1 writeback at cycle 7, instr_done_o once.
- bne (op 0x05) -> alu_ctrl_o=0110, pc_write_cond_o=1, branch_ne_o=1 in cycle 3, back in FETCH at cycle 4.
- Illegal: op 0x3F -> illegal_o pulses in DECODE, FETCH next cycle. R-type funct 0x3F -> illegal_o in R_EXEC, reg_write_o never asserted.
- sll (funct 0x00) -> alu_ctrl_o=0011; lui (op 0x0F) -> alu_ctrl_o=0100 with alu_src_b_o=2. Reset asserted during MEM_WRITE -> mem_write_o=0 that cycle, FETCH after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path: ALU operation
// codes, opcode/funct constants, the main FSM state encoding and the
// ALU-control class used by the ALU op decoder.
package cpu_pkg;

  // ALU operation codes understood by the datapath ALU
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_LUI  = 4'b0100;
  localparam logic [3:0] ALU_SLLV = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  // Main control FSM states; codes 12..15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_R_EXEC    = 4'd2,
    ST_R_WB      = 4'd3,
    ST_I_EXEC    = 4'd4,
    ST_I_WB      = 4'd5,
    ST_MEM_ADDR  = 4'd6,
    ST_MEM_READ  = 4'd7,
    ST_MEM_WB    = 4'd8,
    ST_MEM_WRITE = 4'd9,
    ST_BRANCH    = 4'd10,
    ST_JUMP      = 4'd11
  } state_e;

  // What the ALU is being asked to do in the current state
  typedef enum logic [2:0] {
    ACLS_NONE = 3'd0,  // ALU result unused
    ACLS_ADD  = 3'd1,  // address / PC arithmetic
    ACLS_SUB  = 3'd2,  // branch compare
    ACLS_R    = 3'd3,  // R-type: operation from funct
    ACLS_I    = 3'd4   // I-type: operation from opcode
  } alu_cls_e;

  // Opcodes the FSM knows how to sequence
  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
      OP_ORI, OP_LUI, OP_LW, OP_SW: op_is_legal = 1'b1;
      default:                      op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-path bundle between the main control FSM (master) and the
// multi-cycle datapath / memory (slave).
interface multicycle_ctrl_if;
  logic [5:0] op_i;
  logic [5:0] funct_i;
  logic       mem_ready_i;
  logic       pc_write_o;
  logic       pc_write_cond_o;
  logic       branch_ne_o;
  logic       i_or_d_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       ir_write_o;
  logic       reg_dst_o;
  logic       mem_to_reg_o;
  logic       reg_write_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [1:0] pc_source_o;
  logic [3:0] alu_ctrl_o;
  logic       illegal_o;
  logic       instr_done_o;

  modport master (
    input  op_i, funct_i, mem_ready_i,
    output pc_write_o, pc_write_cond_o, branch_ne_o, i_or_d_o, mem_read_o,
           mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, pc_source_o, alu_ctrl_o, illegal_o,
           instr_done_o
  );

  modport slave (
    output op_i, funct_i, mem_ready_i,
    input  pc_write_o, pc_write_cond_o, branch_ne_o, i_or_d_o, mem_read_o,
           mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, pc_source_o, alu_ctrl_o, illegal_o,
           instr_done_o
  );
endinterface

// File: rtl/alu_op_decode.sv
// Purely combinational ALU-control decoder: maps the requested ALU class
// plus opcode/funct to a 4-bit ALU operation and flags unsupported codes.
// Standalone so the single-cycle core can reuse it.
module alu_op_decode
  import cpu_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       illegal_o
);

  // Select the ALU operation for the requested class
  always_comb begin
    alu_ctrl_o = ALU_AND;
    illegal_o  = 1'b0;
    case (cls_i)
      ACLS_ADD: alu_ctrl_o = ALU_ADD;
      ACLS_SUB: alu_ctrl_o = ALU_SUB;
      ACLS_R: begin
        case (funct_i)
          FUNCT_ADD:  alu_ctrl_o = ALU_ADD;
          FUNCT_SUB:  alu_ctrl_o = ALU_SUB;
          FUNCT_AND:  alu_ctrl_o = ALU_AND;
          FUNCT_OR:   alu_ctrl_o = ALU_OR;
          FUNCT_NOR:  alu_ctrl_o = ALU_NOR;
          FUNCT_SLT:  alu_ctrl_o = ALU_SLT;
          FUNCT_SLL:  alu_ctrl_o = ALU_SLL;
          FUNCT_SLLV: alu_ctrl_o = ALU_SLLV;
          default:    illegal_o  = 1'b1;
        endcase
      end
      ACLS_I: begin
        case (op_i)
          OP_ADDI: alu_ctrl_o = ALU_ADD;
          OP_SLTI: alu_ctrl_o = ALU_SLT;
          OP_ORI:  alu_ctrl_o = ALU_OR;
          OP_LUI:  alu_ctrl_o = ALU_LUI;
          default: illegal_o  = 1'b1;
        endcase
      end
      default: alu_ctrl_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU. Sequences fetch / decode /
// execute / memory / writeback and drives datapath enables, mux selects
// and the ALU operation. Outputs are decoded from the state (plus op/funct
// in the execute states) and are all forced low while reset is asserted.
module multicycle_ctrl
  import cpu_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,   // synchronous, active-low
  multicycle_ctrl_if.master  bus
);

  state_e     state_q, state_d;
  alu_cls_e   alu_cls;
  logic [3:0] dec_alu_ctrl;
  logic       dec_illegal;

  alu_op_decode u_alu_op_decode (
    .cls_i      (alu_cls),
    .op_i       (bus.op_i),
    .funct_i    (bus.funct_i),
    .alu_ctrl_o (dec_alu_ctrl),
    .illegal_o  (dec_illegal)
  );

  // State register: the only flop in the controller
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; memory states hold until the access completes
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = bus.mem_ready_i ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (bus.op_i)
          OP_RTYPE:                         state_d = ST_R_EXEC;
          OP_LW, OP_SW:                     state_d = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:                   state_d = ST_BRANCH;
          OP_ADDI, OP_SLTI, OP_ORI, OP_LUI: state_d = ST_I_EXEC;
          OP_J:                             state_d = ST_JUMP;
          default:                          state_d = ST_FETCH;
        endcase
      end
      ST_R_EXEC:    state_d = dec_illegal ? ST_FETCH : ST_R_WB;
      ST_I_EXEC:    state_d = ST_I_WB;
      ST_MEM_ADDR:  state_d = (bus.op_i == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  state_d = bus.mem_ready_i ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WRITE: state_d = bus.mem_ready_i ? ST_FETCH : ST_MEM_WRITE;
      default:      state_d = ST_FETCH;  // writeback, branch, jump, unused codes
    endcase
  end

  // ALU class per state, feeding the shared op decoder
  always_comb begin
    alu_cls = ACLS_NONE;
    case (state_q)
      ST_FETCH, ST_DECODE, ST_MEM_ADDR: alu_cls = ACLS_ADD;
      ST_R_EXEC:                        alu_cls = ACLS_R;
      ST_I_EXEC:                        alu_cls = ACLS_I;
      ST_BRANCH:                        alu_cls = ACLS_SUB;
      default:                          alu_cls = ACLS_NONE;
    endcase
  end

  // Output decode; everything stays at zero while reset is held low
  always_comb begin
    bus.pc_write_o      = 1'b0;
    bus.pc_write_cond_o = 1'b0;
    bus.branch_ne_o     = 1'b0;
    bus.i_or_d_o        = 1'b0;
    bus.mem_read_o      = 1'b0;
    bus.mem_write_o     = 1'b0;
    bus.ir_write_o      = 1'b0;
    bus.reg_dst_o       = 1'b0;
    bus.mem_to_reg_o    = 1'b0;
    bus.reg_write_o     = 1'b0;
    bus.alu_src_a_o     = 1'b0;
    bus.alu_src_b_o     = 2'd0;
    bus.pc_source_o     = 2'd0;
    bus.alu_ctrl_o      = ALU_AND;
    bus.illegal_o       = 1'b0;
    bus.instr_done_o    = 1'b0;
    if (rst_i) begin
      bus.alu_ctrl_o = dec_alu_ctrl;
      case (state_q)
        ST_FETCH: begin
          bus.mem_read_o  = 1'b1;
          bus.alu_src_b_o = 2'd1;
          bus.ir_write_o  = bus.mem_ready_i;
          bus.pc_write_o  = bus.mem_ready_i;
        end
        ST_DECODE: begin
          bus.alu_src_b_o = 2'd3;
          bus.illegal_o   = !op_is_legal(bus.op_i);
        end
        ST_R_EXEC: begin
          bus.alu_src_a_o = 1'b1;
          bus.illegal_o   = dec_illegal;
        end
        ST_R_WB: begin
          bus.reg_write_o  = 1'b1;
          bus.reg_dst_o    = 1'b1;
          bus.instr_done_o = 1'b1;
        end
        ST_I_EXEC: begin
          bus.alu_src_a_o = 1'b1;
          bus.alu_src_b_o = 2'd2;
          bus.illegal_o   = dec_illegal;
        end
        ST_I_WB: begin
          bus.reg_write_o  = 1'b1;
          bus.instr_done_o = 1'b1;
        end
        ST_MEM_ADDR: begin
          bus.alu_src_a_o = 1'b1;
          bus.alu_src_b_o = 2'd2;
        end
        ST_MEM_READ: begin
          bus.mem_read_o = 1'b1;
          bus.i_or_d_o   = 1'b1;
        end
        ST_MEM_WB: begin
          bus.reg_write_o  = 1'b1;
          bus.mem_to_reg_o = 1'b1;
          bus.instr_done_o = 1'b1;
        end
        ST_MEM_WRITE: begin
          bus.mem_write_o  = 1'b1;
          bus.i_or_d_o     = 1'b1;
          bus.instr_done_o = bus.mem_ready_i;
        end
        ST_BRANCH: begin
          bus.alu_src_a_o     = 1'b1;
          bus.pc_write_cond_o = 1'b1;
          bus.pc_source_o     = 2'd1;
          bus.branch_ne_o     = (bus.op_i == OP_BNE);
          bus.instr_done_o    = 1'b1;
        end
        ST_JUMP: begin
          bus.pc_write_o   = 1'b1;
          bus.pc_source_o  = 2'd2;
          bus.instr_done_o = 1'b1;
        end
        default: bus.alu_ctrl_o = ALU_AND;
      endcase
    end
  end

endmodule
